// File: rtl/exmem_pkg.sv
// Shared definitions for the multi-lane EX/MEM pipeline register: writeback
// select codes, the per-lane control bundle and default widths.
package exmem_pkg;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;

    localparam int unsigned DEF_NUM_LANES = 2;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_REG_AW    = 5;
    localparam int unsigned DEF_PC_W      = 8;
    localparam int unsigned DEF_CNT_W     = 16;

    typedef struct packed {
        logic       valid;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic [1:0] mem_to_reg;
    } lane_ctrl_t;

endpackage

// File: rtl/ex_mem_lane_reg.sv
// One lane of the EX/MEM register. Priority: reset > flush > stall > kill > load.
module ex_mem_lane_reg
    import exmem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned PC_W   = DEF_PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              kill,
    input  lane_ctrl_t        ctrl_ex,
    input  logic [DATA_W-1:0] alu_out_ex,
    input  logic [DATA_W-1:0] rd2_ex,
    input  logic [REG_AW-1:0] dest_ex,
    input  logic [PC_W-1:0]   pc_ex,
    output lane_ctrl_t        ctrl_mem,
    output logic [DATA_W-1:0] alu_out_mem,
    output logic [DATA_W-1:0] rd2_mem,
    output logic [REG_AW-1:0] dest_mem,
    output logic [PC_W-1:0]   pc_mem
);

    // NOTE: every register here uses <= so all lanes and fields update
    // together from pre-edge values; a blocking = would order-couple them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_mem    <= '0;
            alu_out_mem <= '0;
            rd2_mem     <= '0;
            dest_mem    <= '0;
            pc_mem      <= '0;
        end else if (flush) begin
            // Squash to a bubble; payload is kept for trace visibility.
            ctrl_mem <= '0;
        end else if (!stall) begin
            alu_out_mem <= alu_out_ex;
            rd2_mem     <= rd2_ex;
            dest_mem    <= dest_ex;
            pc_mem      <= pc_ex;
            if (kill) begin
                ctrl_mem <= '0;
            end else begin
                // Enables are gated by valid so a bubble never writes anything.
                ctrl_mem.valid      <= ctrl_ex.valid;
                ctrl_mem.mem_rd     <= ctrl_ex.mem_rd & ctrl_ex.valid;
                ctrl_mem.mem_wr     <= ctrl_ex.mem_wr & ctrl_ex.valid;
                ctrl_mem.reg_wr     <= ctrl_ex.reg_wr & ctrl_ex.valid;
                ctrl_mem.mem_to_reg <= ctrl_ex.mem_to_reg;
            end
        end
    end

endmodule

// File: rtl/ex_mem_pipe_mlane.sv
// Multi-lane EX->MEM pipeline register with stall, flush and per-lane kill.
// Define EXMEM_PERF_CNT_EN to add saturating stall/bubble counters.
module ex_mem_pipe_mlane
    import exmem_pkg::*;
#(
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned REG_AW    = DEF_REG_AW,
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [NUM_LANES-1:0]        kill_ex,
    input  logic [NUM_LANES-1:0]        valid_ex,
    input  logic [NUM_LANES*DATA_W-1:0] alu_out_ex,
    input  logic [NUM_LANES*DATA_W-1:0] rd2_ex,
    input  logic [NUM_LANES*REG_AW-1:0] dest_ex,
    input  logic [NUM_LANES*PC_W-1:0]   pc_ex,
    input  logic [NUM_LANES-1:0]        mem_rd_ex,
    input  logic [NUM_LANES-1:0]        mem_wr_ex,
    input  logic [NUM_LANES-1:0]        reg_wr_ex,
    input  logic [NUM_LANES*2-1:0]      mem_to_reg_ex,
    output logic [NUM_LANES-1:0]        valid_mem,
    output logic [NUM_LANES*DATA_W-1:0] alu_out_mem,
    output logic [NUM_LANES*DATA_W-1:0] rd2_mem,
    output logic [NUM_LANES*REG_AW-1:0] dest_mem,
    output logic [NUM_LANES*PC_W-1:0]   pc_mem,
    output logic [NUM_LANES-1:0]        mem_rd_mem,
    output logic [NUM_LANES-1:0]        mem_wr_mem,
    output logic [NUM_LANES-1:0]        reg_wr_mem,
    output logic [NUM_LANES*2-1:0]      mem_to_reg_mem
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            bubble_cnt
`endif
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_ctrl_t ctrl_in;
        lane_ctrl_t ctrl_q;

        assign ctrl_in = '{valid:      valid_ex[i],
                           mem_rd:     mem_rd_ex[i],
                           mem_wr:     mem_wr_ex[i],
                           reg_wr:     reg_wr_ex[i],
                           mem_to_reg: mem_to_reg_ex[i*2 +: 2]};

        ex_mem_lane_reg #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .PC_W   (PC_W)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .stall       (stall),
            .flush       (flush),
            .kill        (kill_ex[i]),
            .ctrl_ex     (ctrl_in),
            .alu_out_ex  (alu_out_ex[i*DATA_W +: DATA_W]),
            .rd2_ex      (rd2_ex[i*DATA_W +: DATA_W]),
            .dest_ex     (dest_ex[i*REG_AW +: REG_AW]),
            .pc_ex       (pc_ex[i*PC_W +: PC_W]),
            .ctrl_mem    (ctrl_q),
            .alu_out_mem (alu_out_mem[i*DATA_W +: DATA_W]),
            .rd2_mem     (rd2_mem[i*DATA_W +: DATA_W]),
            .dest_mem    (dest_mem[i*REG_AW +: REG_AW]),
            .pc_mem      (pc_mem[i*PC_W +: PC_W])
        );

        assign valid_mem[i]             = ctrl_q.valid;
        assign mem_rd_mem[i]            = ctrl_q.mem_rd;
        assign mem_wr_mem[i]            = ctrl_q.mem_wr;
        assign reg_wr_mem[i]            = ctrl_q.reg_wr;
        assign mem_to_reg_mem[i*2 +: 2] = ctrl_q.mem_to_reg;
    end

`ifdef EXMEM_PERF_CNT_EN
    logic any_bubble;

    // A lane enters MEM as a bubble when it is invalid or killed.
    assign any_bubble = |(~valid_ex | kill_ex);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (!flush) begin
            if (stall) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            end else if (any_bubble && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
